// File: rtl/cpu0_pkg.sv
`default_nettype none
// ============================================================================
// Module : cpu0_pkg
// Brief  : Types and constants shared by the CPU0 fetch unit and execute core.
// Rev    : 1.0
// ============================================================================
package cpu0_pkg;

  localparam int INSTR_W = 32;

  // Control-transfer opcodes; the core redirects fetch when it resolves these.
  localparam logic [7:0] JMP  = 8'h26;
  localparam logic [7:0] CALL = 8'h2B;
  localparam logic [7:0] RET  = 8'h2C;
  localparam logic [7:0] SWI  = 8'h2A;

  typedef enum logic [0:0] {
    FETCH = 1'b0,
    FULL  = 1'b1
  } fetch_state_e;

endpackage
`default_nettype wire

// File: rtl/cpu0_fifo.sv
`default_nettype none
// ============================================================================
// Module : cpu0_fifo
// Brief  : Synchronous prefetch FIFO with flush; head is read combinationally.
// Rev    : 1.0
// ============================================================================
module cpu0_fifo
  import cpu0_pkg::*;
#(
  parameter int DEPTH = 4,
  parameter int WIDTH = 2 * INSTR_W,
  localparam int PTR_W = $clog2(DEPTH),
  localparam int CNT_W = PTR_W + 1
) (
  input  logic             clock,
  input  logic             reset_n,
  input  logic             flush,
  input  logic             push,
  input  logic [WIDTH-1:0] wdata,
  input  logic             pop,
  output logic [WIDTH-1:0] rdata,
  output logic             full,
  output logic             empty,
  output logic [CNT_W-1:0] count
);

  logic [WIDTH-1:0] mem_q [DEPTH];
  logic [PTR_W-1:0] wr_ptr_q;
  logic [PTR_W-1:0] rd_ptr_q;
  logic [CNT_W-1:0] count_q;
  logic             w_push;
  logic             w_pop;

  assign full   = (count_q == CNT_W'(DEPTH));
  assign empty  = (count_q == '0);
  assign count  = count_q;
  assign rdata  = mem_q[rd_ptr_q];
  assign w_push = push && !full;
  assign w_pop  = pop && !empty;

  always_ff @(posedge clock) begin
    if (!reset_n || flush) begin
      wr_ptr_q <= '0;
      rd_ptr_q <= '0;
      count_q  <= '0;
    end else begin
      if (w_push) wr_ptr_q <= wr_ptr_q + PTR_W'(1);
      if (w_pop)  rd_ptr_q <= rd_ptr_q + PTR_W'(1);
      case ({w_push, w_pop})
        2'b10:   count_q <= count_q + CNT_W'(1);
        2'b01:   count_q <= count_q - CNT_W'(1);
        default: count_q <= count_q;
      endcase
    end
  end

  // Storage needs no reset: entries are only visible once counted in.
  always_ff @(posedge clock) begin
    if (reset_n && !flush && w_push) mem_q[wr_ptr_q] <= wdata;
  end

endmodule
`default_nettype wire

// File: rtl/cpu0_ifetch.sv
`default_nettype none
// ============================================================================
// Module : cpu0_ifetch
// Brief  : Byte-serial big-endian instruction fetch with prefetch queue.
// Config : CPU0_IFETCH_BYPASS_EN - empty-queue word bypass to ir outputs.
// Rev    : 1.0
// ============================================================================
module cpu0_ifetch
  import cpu0_pkg::*;
#(
  parameter int          DEPTH    = 4,
  parameter logic [31:0] RESET_PC = 32'h0
) (
  input  logic               clock,
  input  logic               reset_n,
  output logic               mem_req,
  output logic [31:0]        mem_addr,
  input  logic               mem_ack,
  input  logic [7:0]         mem_rdata,
  output logic               ir_valid,
  output logic [INSTR_W-1:0] ir,
  output logic [31:0]        ir_pc,
  input  logic               ir_ready,
  input  logic               redirect,
  input  logic [31:0]        redirect_pc
);

  localparam int CNT_W = $clog2(DEPTH) + 1;

  fetch_state_e         state_q, state_d;
  logic                 run_q;
  logic [31:0]          fetch_pc_q, fetch_pc_d;
  logic [1:0]           byte_cnt_q, byte_cnt_d;
  logic [INSTR_W-1:0]   word_q, word_d;

  logic                 w_byte_ack;
  logic                 w_word_done;
  logic [INSTR_W-1:0]   w_word;
  logic                 w_bypass;
  logic                 w_pop;
  logic                 fifo_push;
  logic                 fifo_pop;
  logic [63:0]          fifo_rdata;
  logic                 fifo_full;
  logic                 fifo_empty;
  logic [CNT_W-1:0]     fifo_count;

  // run_q holds mem_req low for the cycle immediately following reset.
  assign mem_req     = run_q && (state_q == FETCH) && !fifo_full;
  assign mem_addr    = fetch_pc_q + {30'd0, byte_cnt_q};
  assign w_byte_ack  = mem_req && mem_ack && !redirect;
  assign w_word_done = w_byte_ack && (byte_cnt_q == 2'd3);
  assign w_word      = {word_q[31:8], mem_rdata};

`ifdef CPU0_IFETCH_BYPASS_EN
  assign w_bypass = fifo_empty && w_word_done;
`else
  assign w_bypass = 1'b0;
`endif

  assign w_pop     = ir_valid && ir_ready;
  assign fifo_push = w_word_done && !(w_bypass && ir_ready);
  assign fifo_pop  = w_pop && !w_bypass;

  cpu0_fifo #(
    .DEPTH (DEPTH),
    .WIDTH (64)
  ) u_fifo (
    .clock   (clock),
    .reset_n (reset_n),
    .flush   (redirect),
    .push    (fifo_push),
    .wdata   ({fetch_pc_q, w_word}),
    .pop     (fifo_pop),
    .rdata   (fifo_rdata),
    .full    (fifo_full),
    .empty   (fifo_empty),
    .count   (fifo_count)
  );

  always_comb begin
    ir_valid = !fifo_empty || w_bypass;
    ir       = '0;
    ir_pc    = '0;
    if (w_bypass) begin
      ir    = w_word;
      ir_pc = fetch_pc_q;
    end else if (!fifo_empty) begin
      ir    = fifo_rdata[31:0];
      ir_pc = fifo_rdata[63:32];
    end
  end

  always_comb begin
    state_d    = state_q;
    fetch_pc_d = fetch_pc_q;
    byte_cnt_d = byte_cnt_q;
    word_d     = word_q;
    if (redirect) begin
      state_d    = FETCH;
      fetch_pc_d = redirect_pc;
      byte_cnt_d = 2'd0;
      word_d     = '0;
    end else begin
      if (w_byte_ack) begin
        byte_cnt_d = byte_cnt_q + 2'd1;
        case (byte_cnt_q)
          2'd0:    word_d[31:24] = mem_rdata;
          2'd1:    word_d[23:16] = mem_rdata;
          2'd2:    word_d[15:8]  = mem_rdata;
          default: word_d[7:0]   = mem_rdata;
        endcase
      end
      if (w_word_done) fetch_pc_d = fetch_pc_q + 32'd4;
      case (state_q)
        FETCH: begin
          if (fifo_push && !fifo_pop && (fifo_count == CNT_W'(DEPTH - 1)))
            state_d = FULL;
        end
        FULL: begin
          if (w_pop) state_d = FETCH;
        end
        default: state_d = FETCH;
      endcase
    end
  end

  always_ff @(posedge clock) begin
    if (!reset_n) begin
      state_q    <= FETCH;
      run_q      <= 1'b0;
      fetch_pc_q <= RESET_PC;
      byte_cnt_q <= 2'd0;
      word_q     <= '0;
    end else begin
      state_q    <= state_d;
      run_q      <= 1'b1;
      fetch_pc_q <= fetch_pc_d;
      byte_cnt_q <= byte_cnt_d;
      word_q     <= word_d;
    end
  end

endmodule
`default_nettype wire

// File: tb/tb_cpu0_ifetch.sv
`default_nettype none
// ============================================================================
// Module : tb_cpu0_ifetch
// Brief  : Directed self-checking bench for cpu0_ifetch against a byte memory.
// Rev    : 1.0
// ============================================================================
module tb_cpu0_ifetch;

`ifdef CPU0_IFETCH_BYPASS_EN
  localparam int FIRST_OFS = 3;
`else
  localparam int FIRST_OFS = 4;
`endif

  logic        clock;
  logic        reset_n;
  logic        mem_req;
  logic [31:0] mem_addr;
  logic        mem_ack;
  logic [7:0]  mem_rdata;
  logic        ir_valid;
  logic [31:0] ir;
  logic [31:0] ir_pc;
  logic        ir_ready;
  logic        redirect;
  logic [31:0] redirect_pc;

  logic        ack_mode;
  logic [1:0]  div_q = 2'd0;
  int          n_total;
  int          n_bad;
  int          cyc;
  logic [31:0] exp_pc [3];
  logic [31:0] exp_ir [3];

  cpu0_ifetch #(
    .DEPTH    (4),
    .RESET_PC (32'h0)
  ) dut (
    .clock       (clock),
    .reset_n     (reset_n),
    .mem_req     (mem_req),
    .mem_addr    (mem_addr),
    .mem_ack     (mem_ack),
    .mem_rdata   (mem_rdata),
    .ir_valid    (ir_valid),
    .ir          (ir),
    .ir_pc       (ir_pc),
    .ir_ready    (ir_ready),
    .redirect    (redirect),
    .redirect_pc (redirect_pc)
  );

  // Memory image: 08 10 00 01 at 0..3, otherwise each byte equals its low address byte.
  function automatic logic [7:0] mem_byte(input logic [31:0] a);
    case (a)
      32'h0:   return 8'h08;
      32'h1:   return 8'h10;
      32'h2:   return 8'h00;
      32'h3:   return 8'h01;
      default: return a[7:0];
    endcase
  endfunction

  assign mem_ack   = mem_req && (!ack_mode || (div_q == 2'd2));
  assign mem_rdata = mem_byte(mem_addr);

  always @(posedge clock) div_q <= (div_q == 2'd2) ? 2'd0 : div_q + 2'd1;

  initial begin
    clock = 1'b0;
    forever #5 clock = ~clock;
  end

  initial begin
    #200000;
    $display("FAIL global_timeout: got no finish, required finish");
    $fatal(1, "bench timeout");
  end

  task automatic tick();
    @(posedge clock);
    #1;
    cyc++;
  endtask

  task automatic wait_until(input int n);
    while (cyc < n) tick();
  endtask

  task automatic chk(input string tag, input logic [31:0] act, input logic [31:0] exp);
    n_total++;
    if (act !== exp) begin
      n_bad++;
      $display("FAIL %s: got %h required %h (cycle %0d)", tag, act, exp, cyc);
    end
  endtask

  task automatic chk_reset(input string tag);
    chk({tag, "_req"},   32'(mem_req),  32'h0);
    chk({tag, "_addr"},  mem_addr,      32'h0);
    chk({tag, "_valid"}, 32'(ir_valid), 32'h0);
    chk({tag, "_ir"},    ir,            32'h0);
    chk({tag, "_pc"},    ir_pc,         32'h0);
  endtask

  task automatic do_reset(input string tag);
    reset_n  = 1'b0;
    redirect = 1'b0;
    tick();
    tick();
    chk_reset(tag);
    reset_n = 1'b1;
    cyc     = 0;
  endtask

  initial begin
    int          got;
    int          base;
    logic        prev_req;
    logic        prev_ack;
    logic [31:0] prev_addr;

    n_total     = 0;
    n_bad       = 0;
    cyc         = 0;
    reset_n     = 1'b0;
    ir_ready    = 1'b0;
    redirect    = 1'b0;
    redirect_pc = 32'h0;
    ack_mode    = 1'b0;
    exp_pc      = '{32'h0, 32'h4, 32'h8};
    exp_ir      = '{32'h08100001, 32'h04050607, 32'h08090A0B};

    // First word from reset, zero-wait memory.
    do_reset("rst0");
    for (int k = 0; k < 4; k++) begin
      tick();
      chk("t1_req", 32'(mem_req), 32'h1);
      chk("t1_addr", mem_addr, 32'(k));
      if (k < FIRST_OFS) chk("t1_novalid", 32'(ir_valid), 32'h0);
    end
    wait_until(FIRST_OFS + 1);
    chk("t1_valid", 32'(ir_valid), 32'h1);
    chk("t1_ir", ir, 32'h08100001);
    chk("t1_pc", ir_pc, 32'h0);

    // Queue fills with ir_ready low, then a single pop restarts fetch.
    wait_until(16);
    chk("t2_req16", 32'(mem_req), 32'h1);
    chk("t2_addr16", mem_addr, 32'hF);
    wait_until(17);
    chk("t2_full_req", 32'(mem_req), 32'h0);
    chk("t2_full_addr", mem_addr, 32'h10);
    chk("t2_full_pc", ir_pc, 32'h0);
    wait_until(19);
    chk("t2_hold_req", 32'(mem_req), 32'h0);
    chk("t2_hold_valid", 32'(ir_valid), 32'h1);
    ir_ready = 1'b1;
    tick();
    ir_ready = 1'b0;
    chk("t2_resume_req", 32'(mem_req), 32'h1);
    chk("t2_resume_addr", mem_addr, 32'h10);
    chk("t2_next_pc", ir_pc, 32'h4);
    chk("t2_next_ir", ir, 32'h04050607);

    // Redirect mid-word with an ack in the same cycle.
    do_reset("rst1");
    wait_until(11);
    chk("t3_pre_addr", mem_addr, 32'hA);
    chk("t3_pre_valid", 32'(ir_valid), 32'h1);
    redirect    = 1'b1;
    redirect_pc = 32'h40;
    tick();
    redirect = 1'b0;
    chk("t3_flush_valid", 32'(ir_valid), 32'h0);
    chk("t3_req", 32'(mem_req), 32'h1);
    chk("t3_addr", mem_addr, 32'h40);
    wait_until(12 + FIRST_OFS);
    chk("t3_valid", 32'(ir_valid), 32'h1);
    chk("t3_pc", ir_pc, 32'h40);
    chk("t3_ir", ir, 32'h40414243);

    // Reset in the middle of the second word.
    do_reset("rst2");
    wait_until(7);
    chk("t5_pre_addr", mem_addr, 32'h6);
    chk("t5_pre_valid", 32'(ir_valid), 32'h1);
    reset_n = 1'b0;
    tick();
    chk_reset("t5_mid");
    reset_n = 1'b1;
    cyc     = 0;
    wait_until(1);
    chk("t5_restart_req", 32'(mem_req), 32'h1);
    chk("t5_restart_addr", mem_addr, 32'h0);
    wait_until(FIRST_OFS + 1);
    chk("t5_valid", 32'(ir_valid), 32'h1);
    chk("t5_pc", ir_pc, 32'h0);
    chk("t5_ir", ir, 32'h08100001);

    // Redirect near the top of the address space, with a pop in the same cycle.
    ir_ready    = 1'b1;
    redirect    = 1'b1;
    redirect_pc = 32'hFFFFFFFC;
    tick();
    redirect = 1'b0;
    base     = cyc;
    for (int k = 0; k < 5; k++) begin
      chk("t6_addr", mem_addr, 32'hFFFFFFFC + 32'(k));
      if (k < FIRST_OFS) chk("t6_novalid", 32'(ir_valid), 32'h0);
      if (k == FIRST_OFS) begin
        chk("t6_valid", 32'(ir_valid), 32'h1);
        chk("t6_pc", ir_pc, 32'hFFFFFFFC);
        chk("t6_ir", ir, 32'hFCFDFEFF);
      end
      if (k < 4) tick();
    end
    wait_until(base + 4 + FIRST_OFS);
    chk("t6_wrap_valid", 32'(ir_valid), 32'h1);
    chk("t6_wrap_pc", ir_pc, 32'h0);
    chk("t6_wrap_ir", ir, 32'h08100001);

    // Slow memory acking every third cycle.
    ack_mode = 1'b1;
    ir_ready = 1'b1;
    do_reset("rst3");
    got       = 0;
    prev_req  = 1'b0;
    prev_ack  = 1'b0;
    prev_addr = 32'h0;
    for (int i = 0; i < 120 && got < 3; i++) begin
      tick();
      if (prev_req && !prev_ack) chk("t4_hold", mem_addr, prev_addr);
      if (ir_valid && ir_ready) begin
        chk("t4_pc", ir_pc, exp_pc[got]);
        chk("t4_ir", ir, exp_ir[got]);
        got++;
      end
      prev_req  = mem_req;
      prev_ack  = mem_ack;
      prev_addr = mem_addr;
    end
    chk("t4_words", 32'(got), 32'h3);

    $display("test done: total=%0d bad=%0d", n_total, n_bad);
    $finish;
  end

endmodule
`default_nettype wire

// File: doc/cpu0_ifetch.md
# cpu0_ifetch

Instruction fetch unit placed directly upstream of the CPU0 execute core. It reads big-endian 32-bit instructions one byte at a time from the byte-wide instruction memory and queues each completed word with its address in a small prefetch queue. The core consumes the queue through a valid/ready handshake. When the core resolves a jump, call, return or software interrupt, it asserts a redirect, which flushes the queue and restarts fetch.

## Interface
- DEPTH, 4: prefetch queue entries; must be a power of two, 2 or greater.
- RESET_PC, 32'h0: fetch address after reset.
- clock  in  1  rising-edge clock.
- reset_n  in  1  reset; synchronous, active-low.
- mem_req  out  1  byte read request, level-sensitive.
- mem_addr  out  32  byte address of the current request.
- mem_ack  in  1  mem_rdata is valid this cycle; may be high in the same cycle as mem_req.
- mem_rdata  in  8  returned byte.
- ir_valid  out  1  queue head is valid.
- ir  out  32  instruction word at the queue head.
- ir_pc  out  32  byte address of ir.
- ir_ready  in  1  core accepts the head this cycle.
- redirect  in  1  flush and restart fetch.
- redirect_pc  in  32  new fetch address; no alignment is required.

## Operation
- Internal state:
  - fetch_pc: address of the word being assembled.
  - byte_cnt: 2 bits.
  - word buffer: 32 bits.
  - queue: DEPTH x {pc, word}, with count.
- mem_addr = fetch_pc + byte_cnt, computed modulo 2^32.
- FSM:
  - FETCH: mem_req=1.
  - FULL: mem_req=0.
  - FETCH to FULL when a push makes count==DEPTH and there is no pop in the same cycle.
  - FULL to FETCH on a pop.
- Byte assembly is big-endian. On mem_ack in FETCH:
  - byte k lands in word[31-8k -: 8].
  - byte_cnt increments.
  - On the 4th byte, {fetch_pc, word} is pushed and fetch_pc += 4 (wraps).
- A pop occurs when ir_valid && ir_ready. A push and a pop in the same cycle leave count unchanged.
- Redirect has priority over everything else in its cycle:
  - queue cleared; ir_valid=0 next cycle.
  - byte_cnt=0 and any partial word is discarded.
  - fetch_pc=redirect_pc.
  - state=FETCH.
  - A mem_ack in the same cycle is ignored, and the accepted pop (if any) is still consumed.
- mem_req is a level, not a transaction. Memory must tolerate mem_addr changing after a redirect without having acked.
- reset_n low at a clock edge sets:
  - fetch_pc=RESET_PC, byte_cnt=0, count=0, state=FETCH.
  - Outputs: mem_req=0, mem_addr=RESET_PC, ir_valid=0, ir=0, ir_pc=0.
  - reset_n low in the middle of a word behaves identically.

## Timing
- Cycle 1 is the first edge with reset_n high. mem_req=1 from that cycle on.
- Zero-wait memory: bytes are acked in cycles 1–4, and ir_valid rises at cycle 5. Sustained rate is one word per 4 cycles.
- mem_addr is stable while mem_req=1 and mem_ack=0.
- After a pop from FULL, mem_req is high in the next cycle.
- Redirect at cycle n: the first request to redirect_pc is issued in cycle n+1, and the first valid word from redirect_pc appears at n+5 with zero-wait memory.
- ir, ir_pc and ir_valid are registered unless the bypass below is compiled in.

## Configuration
- CPU0_IFETCH_BYPASS_EN defined: when the queue is empty and the 4th byte is acked, the assembled word drives ir/ir_pc/ir_valid combinationally in that same cycle.
  - If ir_ready is high, the word is consumed without entering the queue.
  - Zero-wait first-word latency becomes cycle 4.
- Undefined: all outputs are registered and first-word latency is cycle 5.
- Handshake, redirect and reset rules are identical in both builds.

## Structure
- Shared package cpu0_pkg holds:
  - fetch FSM state enum (FETCH, FULL);
  - INSTR_W=32;
  - opcode constants shared with the core (JMP=8'h26, CALL=8'h2B, RET=8'h2C, SWI=8'h2A).
- One sub-module: cpu0_fifo.
  - Synchronous FIFO, DEPTH x 64 bits ({pc, word}).
  - Ports: flush, push, pop, full, empty, count.

## Test plan
- Zero-wait memory holding 08 10 00 01 at address 0 → mem_addr 0,1,2,3 in cycles 1–4; ir=32'h08100001, ir_pc=0 at cycle 5 (cycle 4 with bypass).
- ir_ready=0, DEPTH=4 → mem_req drops after 16 acks with count=4. One cycle of ir_ready=1 → ir_pc=0 popped, mem_req=1 next cycle, mem_addr=0x10.
- Redirect to 0x40 after 2 bytes of word 0x8, with mem_ack in the same cycle → ir_valid=0 next cycle, mem_addr=0x40, first ir_pc=0x40.
- Memory acks every 3rd cycle → mem_addr held between acks; words and ir_pc sequence 0, 4, 8 intact.
- reset_n low after 2 bytes → all outputs at reset values next cycle; fetch restarts at RESET_PC with ir_pc=0.
- Redirect to 0xFFFFFFFC → addresses FC, FD, FE, FF, then 0x0; ir_pc=0xFFFFFFFC, then 0x0.
